// File: rtl/msu_axis_tx.sv
// msu_axis_tx: serialises one {value, end_cnt, start_cnt} load word into
// LSB-first AXI-stream beats with tkeep on the final beat and tlast.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ld_valid / ld_ready        load-word handshake
//   ld_start_cnt, ld_end_cnt   T_LEN-bit counts (start is the lowest bits)
//   ld_value                   DAT_BITS-bit Montgomery-form value
//   m_axis_t*                  AXI-stream master (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_xfer_size_in_bytes  constant packet size in bytes
//   busy                       packet in flight
//
// Build option: define MSU_AXIS_TX_SOP_EN to add m_axis_tsop, which is
// high on beat 0 only (qualified by tvalid).

module msu_axis_tx #(
    parameter int AXI_LEN  = 32,
    parameter int T_LEN    = 64,
    parameter int DAT_BITS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [T_LEN-1:0]      ld_start_cnt,
    input  logic [T_LEN-1:0]      ld_end_cnt,
    input  logic [DAT_BITS-1:0]   ld_value,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AXI_LEN-1:0]    m_axis_tdata,
    output logic [AXI_LEN/8-1:0]  m_axis_tkeep,
    output logic                  m_axis_tlast,
`ifdef MSU_AXIS_TX_SOP_EN
    output logic                  m_axis_tsop,
`endif
    output logic [31:0]           m_axis_xfer_size_in_bytes,
    output logic                  busy
);

    localparam int KW         = AXI_LEN / 8;
    localparam int PKT_BITS   = DAT_BITS + 2 * T_LEN;
    localparam int PKT_BYTS   = (PKT_BITS + 7) / 8;
    localparam int BEATS      = (PKT_BYTS + KW - 1) / KW;
    localparam int SR_W       = BEATS * AXI_LEN;
    localparam int LAST_BYTES = PKT_BYTS - (BEATS - 1) * KW;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic            sending;
    logic            last_beat;
    logic [KW-1:0]   keep;

    assign sending   = (state_q == SEND);
    assign last_beat = (beat_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    // Zero-extended to a whole number of beats so the
                    // padding bytes of the final beat shift out as zero.
                    sr_d    = SR_W'({ld_value, ld_end_cnt, ld_start_cnt});
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    sr_d = sr_q >> AXI_LEN;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            beat_q  <= beat_d;
        end
    end

    // Only the low LAST_BYTES bytes of the final beat are real packet data.
    always_comb begin
        keep = '0;
        for (int i = 0; i < KW; i++) begin
            keep[i] = sending && (!last_beat || (i < LAST_BYTES));
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < KW; i++) begin
            m_axis_tdata[i*8 +: 8] = keep[i] ? sr_q[i*8 +: 8] : 8'h00;
        end
    end

    // All beat fields decode from registered state only, so they cannot
    // depend on tready and stay put while the sink stalls.
    assign m_axis_tkeep  = keep;
    assign m_axis_tvalid = sending;
    assign m_axis_tlast  = sending && last_beat;
    assign ld_ready      = (state_q == IDLE);
    assign busy          = sending;
    assign m_axis_xfer_size_in_bytes = 32'(PKT_BYTS);

`ifdef MSU_AXIS_TX_SOP_EN
    assign m_axis_tsop = sending && (beat_q == '0);
`endif

endmodule

// File: tb/tb_msu_axis_tx.sv
// tb_msu_axis_tx: directed table and sequence checks for msu_axis_tx,
// default build plus a DAT_BITS=1000 instance for the partial final beat.

module tb_msu_axis_tx;

    localparam int NB = 36;

    logic          clk;
    logic          rst_n;
    logic          ld_valid;
    logic [63:0]   ld_start;
    logic [63:0]   ld_end;
    logic [1023:0] ld_value;
    logic          tready;

    logic          ld_ready, tvalid, tlast, busy;
    logic [31:0]   tdata, xfer;
    logic [3:0]    tkeep;
    logic          ld_ready2, tvalid2, tlast2, busy2;
    logic [31:0]   tdata2, xfer2;
    logic [3:0]    tkeep2;
`ifdef MSU_AXIS_TX_SOP_EN
    logic          tsop, tsop2;
`endif

    int nchk = 0;
    int nerr = 0;

    logic [31:0] cap_data  [NB];
    logic [3:0]  cap_keep  [NB];
    logic        cap_last  [NB];
    logic [31:0] cap2_data [NB];
    logic [3:0]  cap2_keep [NB];
    logic        cap2_last [NB];
    int          cap_n, cap2_n;

    msu_axis_tx u_dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .ld_valid                  (ld_valid),
        .ld_ready                  (ld_ready),
        .ld_start_cnt              (ld_start),
        .ld_end_cnt                (ld_end),
        .ld_value                  (ld_value),
        .m_axis_tvalid             (tvalid),
        .m_axis_tready             (tready),
        .m_axis_tdata              (tdata),
        .m_axis_tkeep              (tkeep),
        .m_axis_tlast              (tlast),
`ifdef MSU_AXIS_TX_SOP_EN
        .m_axis_tsop               (tsop),
`endif
        .m_axis_xfer_size_in_bytes (xfer),
        .busy                      (busy)
    );

    msu_axis_tx #(.DAT_BITS(1000)) u_dut2 (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .ld_valid                  (ld_valid),
        .ld_ready                  (ld_ready2),
        .ld_start_cnt              (ld_start),
        .ld_end_cnt                (ld_end),
        .ld_value                  (ld_value[999:0]),
        .m_axis_tvalid             (tvalid2),
        .m_axis_tready             (tready),
        .m_axis_tdata              (tdata2),
        .m_axis_tkeep              (tkeep2),
        .m_axis_tlast              (tlast2),
`ifdef MSU_AXIS_TX_SOP_EN
        .m_axis_tsop               (tsop2),
`endif
        .m_axis_xfer_size_in_bytes (xfer2),
        .busy                      (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last captured beat.
    task automatic collect(input int mode, input int nb, input int maxcyc);
        int          cyc;
        logic        stl;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        cyc    = 0;
        stl    = 1'b0;
        pd     = '0;
        pk     = '0;
        pl     = 1'b0;
        cap_n  = 0;
        cap2_n = 0;
        while (cap_n < nb && cyc < maxcyc) begin
            case (mode)
                1:       tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       tready = (cyc >= 3);
                default: tready = 1'b1;
            endcase
            if (stl) begin
                chk("stall_data", tdata, pd);
                chk("stall_keep", tkeep, pk);
                chk("stall_last", tlast, pl);
            end
            if (cap_n > 0) chk("valid_held", tvalid, 1);
            if (tvalid) begin
                chk("ready_busy_in_pkt", {ld_ready, busy}, 2'b01);
`ifdef MSU_AXIS_TX_SOP_EN
                chk("tsop", tsop, (cap_n == 0));
                chk("tsop2", tsop2, (cap2_n == 0));
`endif
            end
            stl = tvalid && !tready;
            pd  = tdata;
            pk  = tkeep;
            pl  = tlast;
            if (tvalid && tready) begin
                cap_data[cap_n] = tdata;
                cap_keep[cap_n] = tkeep;
                cap_last[cap_n] = tlast;
                cap_n++;
            end
            if (tvalid2 && tready && cap2_n < NB) begin
                cap2_data[cap2_n] = tdata2;
                cap2_keep[cap2_n] = tkeep2;
                cap2_last[cap2_n] = tlast2;
                cap2_n++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cap_n < nb) chk("collect_timeout", cap_n, nb);
        tready = 1'b1;
    endtask

    task automatic load(input logic [63:0] s, input logic [63:0] e,
                        input logic [1023:0] v);
        ld_start = s;
        ld_end   = e;
        ld_value = v;
        ld_valid = 1'b1;
        chk("ld_ready_idle", ld_ready, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        chk("tvalid_latency", tvalid, 1);
    endtask

    typedef struct {
        int          beat;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } vec_t;

    vec_t           tbl[10];
    logic [1151:0]  exp1, exp2;
    logic [63:0]    ps, pe;
    logic [1023:0]  pv;

    initial begin
        tbl[0] = '{0,  32'h0, 4'hF, 1'b0};
        tbl[1] = '{1,  32'h0, 4'hF, 1'b0};
        tbl[2] = '{2,  32'hA, 4'hF, 1'b0};
        tbl[3] = '{3,  32'h0, 4'hF, 1'b0};
        tbl[4] = '{4,  32'h2, 4'hF, 1'b0};
        tbl[5] = '{5,  32'h0, 4'hF, 1'b0};
        tbl[6] = '{20, 32'h0, 4'hF, 1'b0};
        tbl[7] = '{33, 32'h0, 4'hF, 1'b0};
        tbl[8] = '{34, 32'h0, 4'hF, 1'b0};
        tbl[9] = '{35, 32'h0, 4'hF, 1'b1};

        ps = 64'h0706050403020100;
        pe = 64'h0F0E0D0C0B0A0908;
        pv = '1;
        pv[63:0] = 64'h1716151413121110;
        exp1 = {pv, pe, ps};
        exp2 = 1152'({pv[999:0], pe, ps});

        rst_n    = 1'b1;
        ld_valid = 1'b0;
        ld_start = '0;
        ld_end   = '0;
        ld_value = '0;
        tready   = 1'b1;
        #1 rst_n = 1'b0;
        #4;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_busy", busy, 0);
        chk("xfer_size", xfer, 144);
        chk("xfer_size2", xfer2, 141);
        #17 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: start=0, end=10, value=2, tready high.
        load(64'd0, 64'd10, 1024'd2);
        collect(0, NB, 200);
        for (int i = 0; i < 10; i++) begin
            chk("s1_data", cap_data[tbl[i].beat], tbl[i].data);
            chk("s1_keep", cap_keep[tbl[i].beat], tbl[i].keep);
            chk("s1_last", cap_last[tbl[i].beat], tbl[i].last);
        end
        chk("s1_dut2_keep35", cap2_keep[35], 4'b0001);
        chk("s1_dut2_last35", cap2_last[35], 1);
        chk("s1_dut2_data35", cap2_data[35], 32'h0);
        chk("s1_end_tvalid", tvalid, 0);
        chk("s1_end_ld_ready", ld_ready, 1);
        chk("s1_end_busy", busy, 0);
        chk("s1_end_tkeep", tkeep, 0);

        // Scenario 3: pattern load with tready 1,0,0,1 and full model check.
        load(ps, pe, pv);
        collect(1, NB, 400);
        for (int k = 0; k < NB; k++) begin
            chk("s3_data", cap_data[k], exp1[k*32 +: 32]);
            chk("s3_keep", cap_keep[k], 4'hF);
            chk("s3_last", cap_last[k], (k == NB - 1));
            chk("s3_data2", cap2_data[k], exp2[k*32 +: 32]);
            chk("s3_keep2", cap2_keep[k], (k == NB - 1) ? 4'b0001 : 4'hF);
            chk("s3_last2", cap2_last[k], (k == NB - 1));
        end
        chk("s3_dut2_mask", cap2_data[35], 32'h000000FF);

        // Scenario 4: ld_valid held high, ld_value changed while busy.
        ld_start = 64'd0;
        ld_end   = 64'd10;
        ld_value = 1024'd2;
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        ld_value = 1024'd5;
        collect(0, NB, 200);
        chk("s4_pkt1_value", cap_data[4], 32'h2);
        chk("s4_gap_tvalid", tvalid, 0);
        chk("s4_gap_ld_ready", ld_ready, 1);
        @(posedge clk);
        #1;
        chk("s4_pkt2_tvalid", tvalid, 1);
        ld_valid = 1'b0;
        collect(0, NB, 200);
        chk("s4_pkt2_value", cap_data[4], 32'h5);
        chk("s4_pkt2_last", cap_last[35], 1);

        // Scenario 5: reset at beat 10.
        load(ps, pe, pv);
        collect(0, 10, 100);
        chk("s5_pre_tvalid", tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_tvalid", tvalid, 0);
        chk("s5_rst_tlast", tlast, 0);
        chk("s5_rst_tdata", tdata, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_ld_ready", ld_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_post_ld_ready", ld_ready, 1);
        load(64'hAABBCCDD11223344, 64'd10, 1024'd2);
        collect(0, NB, 200);
        chk("s5_restart_beat0", cap_data[0], 32'h11223344);
        chk("s5_restart_beat1", cap_data[1], 32'hAABBCCDD);
        chk("s5_restart_last", cap_last[35], 1);

        // Scenario 6: beat 0 stalled for 3 cycles (tsop checked when built).
        load(64'd0, 64'd10, 1024'd2);
        collect(2, NB, 200);
        chk("s6_beat0", cap_data[0], 32'h0);
        chk("s6_beat2", cap_data[2], 32'hA);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
